hls_deadlock_persist_monitor: RTL
=================================

Name: hls_deadlock_persist_monitor

Overview:
- Parametrised successor to the per-dataflow-region HLS deadlock monitors; one instance per dataflow region, fed by the region's process status bits.
- Watches NUM_PROC processes and flags a deadlock when at least one process is blocked on an AXI-Stream and every process is idle, channel-blocked or AXIS-blocked.
- Unlike the single-cycle monitor, the condition must persist THRESHOLD consecutive cycles before `block` asserts.
- Adds a sticky latch, a first-detection snapshot of the AXIS-blocked processes, a stall-length counter and an event pulse for the debug/status path.

Parameters:
- NUM_PROC, 2, number of monitored processes (>=1).
- CNT_W, 16, width of the stall-length counter.
- THRESHOLD, 1, consecutive cycles of deadlock condition required before assertion (1..2^CNT_W-1). THRESHOLD=1 reproduces legacy 1-cycle-latency behaviour.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- axis_block_sigs  in  NUM_PROC  bit i = process i stalled on an AXIS port.
- inst_idle_sigs  in  NUM_PROC  bit i = process i idle.
- inst_block_sigs  in  NUM_PROC  bit i = process i blocked on an internal channel.
- clear  in  1  synchronous clear of sticky latch and snapshot.
- block  out  1  live deadlock indication (registered).
- block_event  out  1  one-cycle pulse on each entry into FIRED.
- block_sticky  out  1  set on first detection, held until clear.
- block_proc_vec  out  NUM_PROC  snapshot of axis_block_sigs at first detection since last clear.
- stall_cnt  out  CNT_W  consecutive cycles the condition has held; saturating.

Behaviour:
- Combinational terms:
  - has_axis = OR of axis_block_sigs.
  - all_stop = AND over i of (idle[i] | chan_block[i] | axis_block[i]).
  - cond = has_axis & all_stop.
- Reset (async, reset=1): state=IDLE; all outputs 0; stall_cnt=0; block_proc_vec=0.
- stall_cnt update, every cycle:
  - next = cond ? min(stall_cnt+1, 2^CNT_W-1) : 0.
  - Saturates and never wraps.
- FSM states: IDLE, COUNT, FIRED. Let n = stall_cnt+1, saturated.
  - IDLE: cond & n>=THRESHOLD → FIRED; cond → COUNT; otherwise stay.
  - COUNT: !cond → IDLE; n>=THRESHOLD → FIRED; otherwise stay.
  - FIRED: !cond → IDLE; otherwise stay.
- block = (state==FIRED) as a register. Latency: the first cycle with cond high is cycle 0; block goes high at the clock edge ending cycle THRESHOLD-1.
- block drops at the edge after the first cycle with cond low. A single-cycle drop of cond restarts counting from 0.
- block_event = 1 for exactly the first cycle that block is 1 after each IDLE/COUNT→FIRED transition.
- Sticky latch and snapshot:
  - On the edge entering FIRED, if block_sticky==0: block_sticky←1 and block_proc_vec←axis_block_sigs sampled that cycle.
  - Later entries do not overwrite the snapshot.
- clear:
  - Zeroes block_sticky and block_proc_vec at the next edge.
  - Does not affect the FSM, block or stall_cnt.
  - If clear and a FIRED entry occur in the same cycle, clear wins. The latch is not re-set until the next FIRED entry, because the latch sets only on entry.
- No process with axis_block set (cond=0) can never fire, even if all processes are idle.
- A reset pulse mid-COUNT or mid-FIRED returns everything to reset values immediately. Counting restarts after reset release.

Test Plan:
- THRESHOLD=1, NUM_PROC=2: axis=01, idle=10, chan=00 for 1 cycle → block=1 and block_event=1 next cycle; block_proc_vec=01; block=0 the cycle after cond drops.
- THRESHOLD=8: cond high for 7 cycles then low → block never asserts, stall_cnt peaks at 7 then returns to 0. Cond high for 8 cycles → block rises at the edge ending cycle 7, event pulses once.
- NUM_PROC=4: idle=1111, axis=0000 for 100 cycles → block stays 0, stall_cnt stays 0. Then axis=0100 with process 2 still stopped → fires after THRESHOLD cycles, snapshot=0100.
- Two fire episodes, axis=0001 then axis=0010, no clear → block_sticky stays 1, block_proc_vec stays 0001. Pulse clear → both 0. Third episode → snapshot=0010.
- CNT_W=4, THRESHOLD=3: hold cond for 40 cycles → stall_cnt saturates at 15, block stays 1; assert reset asynchronously mid-cycle → block, stall_cnt, block_sticky zero without waiting for a clock edge.

Source files
------------

// File: rtl/hls_deadlock_persist_monitor_if.sv
// Status and debug bundle between one dataflow region and its deadlock monitor.
// valid/ready: none; every signal is a level sampled on each rising clock edge.
interface hls_deadlock_persist_monitor_if #(
    parameter int NUM_PROC = 2,
    parameter int CNT_W    = 16
);
    logic [NUM_PROC-1:0] axis_block_sigs;
    logic [NUM_PROC-1:0] inst_idle_sigs;
    logic [NUM_PROC-1:0] inst_block_sigs;
    logic                clear;
    logic                block;
    logic                block_event;
    logic                block_sticky;
    logic [NUM_PROC-1:0] block_proc_vec;
    logic [CNT_W-1:0]    stall_cnt;
    logic [1:0]          fsm_state;

    modport master (
        output axis_block_sigs, inst_idle_sigs, inst_block_sigs, clear,
        input  block, block_event, block_sticky, block_proc_vec, stall_cnt, fsm_state
    );

    modport slave (
        input  axis_block_sigs, inst_idle_sigs, inst_block_sigs, clear,
        output block, block_event, block_sticky, block_proc_vec, stall_cnt, fsm_state
    );
endinterface

// File: rtl/hls_deadlock_persist_monitor.sv
// Flags a dataflow-region deadlock once "some process AXIS-blocked, all stopped" has held
// THRESHOLD consecutive cycles; keeps a sticky flag, first-hit snapshot and stall counter.
module hls_deadlock_persist_monitor #(
    parameter int NUM_PROC  = 2,
    parameter int CNT_W     = 16,
    parameter int THRESHOLD = 1
) (
    input  logic clock,
    input  logic reset,
    hls_deadlock_persist_monitor_if.slave mon
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        FIRED = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESHOLD);

    state_t              state;
    state_t              state_next;
    logic                has_axis;
    logic                all_stop;
    logic                cond;
    logic                entry;
    logic [CNT_W-1:0]    cnt_inc;
    logic [CNT_W-1:0]    stall_q;
    logic                event_q;
    logic                sticky_q;
    logic [NUM_PROC-1:0] vec_q;

    always_comb begin
        has_axis = |mon.axis_block_sigs;
        all_stop = &(mon.inst_idle_sigs | mon.inst_block_sigs | mon.axis_block_sigs);
        cond     = has_axis & all_stop;
        cnt_inc  = (stall_q == CNT_MAX) ? CNT_MAX : stall_q + 1'b1;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cond && cnt_inc >= THR)  state_next = FIRED;
                else if (cond)               state_next = COUNT;
            end
            COUNT: begin
                if (!cond)                   state_next = IDLE;
                else if (cnt_inc >= THR)     state_next = FIRED;
            end
            FIRED: begin
                if (!cond)                   state_next = IDLE;
            end
            default:                         state_next = IDLE;
        endcase
        entry = (state_next == FIRED) && (state != FIRED);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_q  <= '0;
            event_q  <= 1'b0;
            sticky_q <= 1'b0;
            vec_q    <= '0;
        end else begin
            stall_q <= cond ? cnt_inc : '0;
            event_q <= entry;
            // clear beats a simultaneous entry; the latch only re-arms on a later entry
            if (mon.clear) begin
                sticky_q <= 1'b0;
                vec_q    <= '0;
            end else if (entry && !sticky_q) begin
                sticky_q <= 1'b1;
                vec_q    <= mon.axis_block_sigs;
            end
        end
    end

    assign mon.block          = (state == FIRED);
    assign mon.block_event    = event_q;
    assign mon.block_sticky   = sticky_q;
    assign mon.block_proc_vec = vec_q;
    assign mon.stall_cnt      = stall_q;
    assign mon.fsm_state      = state;
endmodule
